text_fill_mod: RTL and testbench
================================

Name: text_fill_mod

Overview:
- Hardware block-fill engine on the cpu_clock side of the text memory, between command_mod and port A of the shared text RAM.
- Writes one fill word per cycle to a range of text cells, e.g. clear screen or clear a line, so the CPU does not issue thousands of bus writes.
- Muxes command_mod's own single-word writes onto the same port. CPU writes always have priority.

Parameters:
- ADDR_WIDTH, 12, text memory address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 16, text cell width (char byte + attribute byte).

Ports:
- cpu_clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle fill request from command_mod.
- start_addr  in  ADDR_WIDTH  first cell to write.
- fill_count  in  ADDR_WIDTH+1  number of cells; 0 = no-op; values above 2^ADDR_WIDTH clamp to 2^ADDR_WIDTH.
- fill_data  in  DATA_WIDTH  word written to every cell.
- abort  in  1  cancel an active fill.
- host_wr_en  in  1  single-word write request from command_mod.
- host_wr_addr  in  ADDR_WIDTH  host write address.
- host_wr_data  in  DATA_WIDTH  host write data.
- text_addr  out  ADDR_WIDTH  RAM port A address (registered).
- text_data  out  DATA_WIDTH  RAM port A data (registered).
- text_enable  out  1  RAM port A write strobe (registered).
- busy  out  1  high while state is FILL or DONE.
- done  out  1  one-cycle pulse on fill completion.

Behaviour:
- Interface (already decided): one clock, cpu_clock; reset is synchronous and active-high.
- Reset:
  - State = IDLE.
  - text_addr, text_data, text_enable, busy and done all 0.
  - Internal address, count and data registers cleared.
  - Reset mid-fill kills the fill immediately; no further writes occur.
- All outputs are registered. A request sampled at edge N appears on port A after edge N, i.e. one cycle of latency for both host and fill writes.
- Port A mux, evaluated every cycle, in priority order:
  - host_wr_en=1: issue the host write; any fill stalls, with address and count held.
  - Else state=FILL and abort=0: issue a fill write.
  - Else: text_enable=0; text_addr/text_data hold their last values.
- IDLE:
  - start=1, clamped count != 0: latch start_addr, count and fill_data; go to FILL.
  - start=1, count == 0: go to DONE; no writes.
  - busy rises on the edge that leaves IDLE.
- FILL:
  - On each non-stalled cycle: write cur_addr, then cur_addr += 1 (mod 2^ADDR_WIDTH, so 4095 -> 0), then remaining -= 1.
  - The write that takes remaining from 1 to 0 moves the state to DONE.
- DONE: done=1 for exactly one cycle, busy=0 from the next edge, state -> IDLE.
- start while busy: ignored; latched values are not disturbed.
- abort:
  - Only acts in FILL. State -> IDLE on that edge, busy=0, no done pulse.
  - A fill write is not issued in the abort cycle; a host write in that cycle is still passed through.
  - In IDLE or DONE, abort is ignored.
- start and abort together in IDLE: start wins.
- Throughput: 1 cell/cycle when no host writes arrive. A full 4096-cell fill completes in 4096 cycles + 1 (DONE).

Optional Feature:
- Macro: TEXT_FILL_INC_EN.
- Defined:
  - After each fill write, the low byte of the data register increments (mod 256); the high (attribute) byte is held.
  - Host-stalled cycles do not increment.
  - Used to paint a font test screen (cells 0x00..0xFF repeating).
- Undefined: every cell receives fill_data unchanged; no incrementer logic is synthesised.

Test Plan:
1. Reset with random inputs toggling -> all outputs 0 during and one cycle after reset; start after reset behaves normally.
2. start, start_addr=0x100, fill_count=4, fill_data=0x0720 -> text_enable high 4 consecutive cycles, addresses 0x100..0x103, data 0x0720; done pulses 1 cycle after the last write; busy high for 5 cycles.
3. Wrap and host priority:
   - start_addr=0xFFE, fill_count=4, host_wr_en pulsed on the second fill cycle (addr 0x050, data 0xBEEF).
   - Expected port A sequence: 0xFFE, 0x050/0xBEEF, 0xFFF, 0x000, 0x001. Total 5 write cycles, then done.
4. fill_count=0 -> no text_enable; done pulse one cycle after start. fill_count=0x1FFF -> exactly 4096 writes.
5. abort on the third FILL cycle of a 10-cell fill -> exactly 2 writes, busy drops, no done. Second start during the fill is ignored.
6. TEXT_FILL_INC_EN defined, fill_data=0x07FE, count=4 -> data 0x07FE, 0x07FF, 0x0700, 0x0701. With the macro undefined -> all 0x07FE.

Source files
------------

// File: rtl/text_fill_mod.sv
// Block-fill engine for text RAM port A: streams one fill word per cycle and muxes host writes ahead of fill writes.
// Optional macro TEXT_FILL_INC_EN: low byte of the fill word increments after every fill write.
module text_fill_mod #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  cpu_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   fill_count,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  abort,
    input  logic                  host_wr_en,
    input  logic [ADDR_WIDTH-1:0] host_wr_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    output logic [ADDR_WIDTH-1:0] text_addr,
    output logic [DATA_WIDTH-1:0] text_data,
    output logic                  text_enable,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADDR_WIDTH-1:0]   text_addr_q, text_addr_d;
    logic [DATA_WIDTH-1:0]   text_data_q, text_data_d;
    logic                    text_en_q, text_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH:0]     count_clamped;
    logic                    fill_go;

    // Counts beyond the memory size would only rewrite cells already filled.
    assign count_clamped = (fill_count > MAX_COUNT) ? MAX_COUNT : fill_count;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        fill_go     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count_clamped != '0) begin
                        addr_d      = start_addr;
                        remaining_d = count_clamped;
                        data_d      = fill_data;
                        state_d     = ST_FILL;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!host_wr_en) begin
                    fill_go     = 1'b1;
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - CNT_ONE;
`ifdef TEXT_FILL_INC_EN
                    data_d[7:0] = data_q[7:0] + 8'd1;
`endif
                    if (remaining_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Port A mux: host writes always win; idle cycles keep the last address/data on the bus.
    always_comb begin
        text_addr_d = text_addr_q;
        text_data_d = text_data_q;
        text_en_d   = 1'b0;
        if (host_wr_en) begin
            text_en_d   = 1'b1;
            text_addr_d = host_wr_addr;
            text_data_d = host_wr_data;
        end else if (fill_go) begin
            text_en_d   = 1'b1;
            text_addr_d = addr_q;
            text_data_d = data_q;
        end
    end

    assign busy_d = (state_d != ST_IDLE);
    assign done_d = (state_q == ST_DONE);

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            text_addr_q <= '0;
            text_data_q <= '0;
            text_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            text_addr_q <= text_addr_d;
            text_data_q <= text_data_d;
            text_en_q   <= text_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign text_addr   = text_addr_q;
    assign text_data   = text_data_q;
    assign text_enable = text_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_text_fill_mod.sv
// Directed bench for text_fill_mod: port A writes are logged on the falling edge and checked per scenario.
module tb_text_fill_mod;
    localparam int AW = 12;
    localparam int DW = 16;
`ifdef TEXT_FILL_INC_EN
    localparam bit INC = 1'b1;
`else
    localparam bit INC = 1'b0;
`endif

    logic          cpu_clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   fill_count = '0;
    logic [DW-1:0] fill_data = '0;
    logic          abort = 1'b0;
    logic          host_wr_en = 1'b0;
    logic [AW-1:0] host_wr_addr = '0;
    logic [DW-1:0] host_wr_data = '0;
    logic [AW-1:0] text_addr;
    logic [DW-1:0] text_data;
    logic          text_enable;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;
    int cycle_cnt = 0;
    int start_cyc;

    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    int            log_cyc[$];
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            busy_cnt = 0;

    text_fill_mod #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .cpu_clock   (cpu_clock),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .fill_count  (fill_count),
        .fill_data   (fill_data),
        .abort       (abort),
        .host_wr_en  (host_wr_en),
        .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data),
        .text_addr   (text_addr),
        .text_data   (text_data),
        .text_enable (text_enable),
        .busy        (busy),
        .done        (done)
    );

    always #5 cpu_clock = ~cpu_clock;

    always @(posedge cpu_clock) cycle_cnt <= cycle_cnt + 1;

    always @(negedge cpu_clock) begin
        if (text_enable) begin
            log_addr.push_back(text_addr);
            log_data.push_back(text_data);
            log_cyc.push_back(cycle_cnt);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cycle_cnt;
        end
        if (busy) busy_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] exp_data(input logic [DW-1:0] base, input int idx);
        logic [7:0] lo;
        lo = base[7:0] + idx[7:0];
        return INC ? {base[DW-1:8], lo} : base;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge cpu_clock);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        busy_cnt = 0;
    endtask

    task automatic launch(input logic [AW-1:0] a, input logic [AW:0] c, input logic [DW-1:0] d);
        start_addr = a;
        fill_count = c;
        fill_data  = d;
        start      = 1'b1;
        step(1);
        start_cyc = cycle_cnt;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start        = 1'($urandom);
            abort        = 1'($urandom);
            host_wr_en   = 1'($urandom);
            start_addr   = AW'($urandom);
            fill_count   = (AW+1)'($urandom);
            fill_data    = DW'($urandom);
            host_wr_addr = AW'($urandom);
            host_wr_data = DW'($urandom);
            step(1);
            checks++;
            if ({text_addr, text_data, text_enable, busy, done} !== '0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got addr=%h data=%h en=%b busy=%b done=%b, want all 0",
                         i, text_addr, text_data, text_enable, busy, done);
            end
        end
        {start, abort, host_wr_en} = 3'b000;
        reset = 1'b0;
        step(1);
        checks++;
        if ({text_addr, text_data, text_enable, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_after: got addr=%h data=%h en=%b busy=%b done=%b, want all 0",
                     text_addr, text_data, text_enable, busy, done);
        end
        // Reset in the middle of a long fill must stop it dead.
        launch(12'h010, 13'd20, 16'h5555);
        step(3);
        reset = 1'b1;
        step(1);
        clear_log();
        checks++;
        if (text_enable !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_midfill: got en=%b busy=%b, want 0 0", text_enable, busy);
        end
        reset = 1'b0;
        step(6);
        checks++;
        if (log_addr.size() != 0 || done_cnt != 0) begin
            failures++;
            $display("FAIL reset_midfill_quiet: got writes=%0d done=%0d, want 0 0", log_addr.size(), done_cnt);
        end
    endtask

    task automatic test_basic_fill();
        clear_log();
        launch(12'h100, 13'd4, 16'h0720);
        step(10);
        checks++;
        if (log_addr.size() != 4) begin
            failures++;
            $display("FAIL basic_count: got %0d writes, want 4", log_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[i] !== AW'(12'h100 + i) || log_data[i] !== exp_data(16'h0720, i)
                || log_cyc[i] != start_cyc + 1 + i) begin
                failures++;
                $display("FAIL basic_write[%0d]: got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                         i, log_addr[i], log_data[i], log_cyc[i], AW'(12'h100 + i),
                         exp_data(16'h0720, i), start_cyc + 1 + i);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != start_cyc + 5) begin
            failures++;
            $display("FAIL basic_done: got pulses=%0d at %0d, want 1 at %0d", done_cnt, done_cyc, start_cyc + 5);
        end
        checks++;
        if (busy_cnt != 5) begin
            failures++;
            $display("FAIL basic_busy: got %0d busy cycles, want 5", busy_cnt);
        end
    endtask

    task automatic test_wrap_host();
        logic [AW-1:0] ea[5];
        logic [DW-1:0] ed[5];
        ea = '{12'hFFE, 12'h050, 12'hFFF, 12'h000, 12'h001};
        ed = '{exp_data(16'h0720, 0), 16'hBEEF, exp_data(16'h0720, 1),
               exp_data(16'h0720, 2), exp_data(16'h0720, 3)};
        clear_log();
        launch(12'hFFE, 13'd4, 16'h0720);
        step(1);
        host_wr_en   = 1'b1;
        host_wr_addr = 12'h050;
        host_wr_data = 16'hBEEF;
        step(1);
        host_wr_en = 1'b0;
        step(8);
        checks++;
        if (log_addr.size() != 5) begin
            failures++;
            $display("FAIL wrap_count: got %0d writes, want 5", log_addr.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] || log_cyc[i] != start_cyc + 1 + i) begin
                failures++;
                $display("FAIL wrap_write[%0d]: got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                         i, log_addr[i], log_data[i], log_cyc[i], ea[i], ed[i], start_cyc + 1 + i);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != start_cyc + 6) begin
            failures++;
            $display("FAIL wrap_done: got pulses=%0d at %0d, want 1 at %0d", done_cnt, done_cyc, start_cyc + 6);
        end
    endtask

    task automatic test_zero_count();
        clear_log();
        launch(12'h300, 13'd0, 16'hAAAA);
        step(5);
        checks++;
        if (log_addr.size() != 0 || done_cnt != 1 || done_cyc != start_cyc + 1 || busy_cnt != 1) begin
            failures++;
            $display("FAIL zero_count: got writes=%0d done=%0d at %0d busy=%0d, want 0 1 at %0d 1",
                     log_addr.size(), done_cnt, done_cyc, busy_cnt, start_cyc + 1);
        end
    endtask

    task automatic test_full_clamp();
        int bad;
        clear_log();
        launch(12'h123, 13'h1FFF, 16'h0941);
        step(4110);
        checks++;
        if (log_addr.size() != 4096) begin
            failures++;
            $display("FAIL full_count: got %0d writes, want 4096", log_addr.size());
        end
        bad = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            if (log_addr[i] !== AW'(12'h123 + i) || log_data[i] !== exp_data(16'h0941, i)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_sequence: got %0d bad writes, want 0", bad);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != start_cyc + 4097) begin
            failures++;
            $display("FAIL full_done: got pulses=%0d at %0d, want 1 at %0d", done_cnt, done_cyc, start_cyc + 4097);
        end
    endtask

    task automatic test_abort();
        clear_log();
        launch(12'h200, 13'd10, 16'h1111);
        start_addr = 12'h300;
        fill_count = 13'd3;
        fill_data  = 16'h2222;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        step(6);
        checks++;
        if (log_addr.size() != 2) begin
            failures++;
            $display("FAIL abort_count: got %0d writes, want 2", log_addr.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (log_addr[i] !== AW'(12'h200 + i) || log_data[i] !== exp_data(16'h1111, i)) begin
                failures++;
                $display("FAIL abort_write[%0d]: got addr=%h data=%h, want addr=%h data=%h",
                         i, log_addr[i], log_data[i], AW'(12'h200 + i), exp_data(16'h1111, i));
            end
        end
        checks++;
        if (done_cnt != 0 || busy_cnt != 3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_status: got done=%0d busy_cycles=%0d busy=%b, want 0 3 0",
                     done_cnt, busy_cnt, busy);
        end
    endtask

    task automatic test_start_beats_abort();
        clear_log();
        abort = 1'b1;
        step(1);
        checks++;
        if (busy !== 1'b0 || text_enable !== 1'b0) begin
            failures++;
            $display("FAIL idle_abort: got busy=%b en=%b, want 0 0", busy, text_enable);
        end
        launch(12'h040, 13'd2, 16'h3333);
        abort = 1'b0;
        step(5);
        checks++;
        if (log_addr.size() != 2 || log_addr[0] !== 12'h040 || log_addr[1] !== 12'h041 || done_cnt != 1) begin
            failures++;
            $display("FAIL start_wins: got writes=%0d first=%h second=%h done=%0d, want 2 040 041 1",
                     log_addr.size(), log_addr[0], log_addr[1], done_cnt);
        end
    endtask

    task automatic test_back_to_back_host();
        host_wr_en   = 1'b1;
        host_wr_addr = 12'h7AB;
        host_wr_data = 16'hCAFE;
        step(1);
        checks++;
        if (text_enable !== 1'b1 || text_addr !== 12'h7AB || text_data !== 16'hCAFE) begin
            failures++;
            $display("FAIL host_first: got en=%b addr=%h data=%h, want 1 7ab cafe", text_enable, text_addr, text_data);
        end
        host_wr_addr = 12'h7AC;
        host_wr_data = 16'hF00D;
        step(1);
        host_wr_en = 1'b0;
        checks++;
        if (text_enable !== 1'b1 || text_addr !== 12'h7AC || text_data !== 16'hF00D) begin
            failures++;
            $display("FAIL host_second: got en=%b addr=%h data=%h, want 1 7ac f00d", text_enable, text_addr, text_data);
        end
        step(1);
        checks++;
        if (text_enable !== 1'b0 || text_addr !== 12'h7AC || text_data !== 16'hF00D) begin
            failures++;
            $display("FAIL host_hold: got en=%b addr=%h data=%h, want 0 7ac f00d", text_enable, text_addr, text_data);
        end
    endtask

    task automatic test_inc_feature();
        logic [DW-1:0] ed[4];
        if (INC) ed = '{16'h07FE, 16'h07FF, 16'h0700, 16'h0701};
        else     ed = '{16'h07FE, 16'h07FE, 16'h07FE, 16'h07FE};
        clear_log();
        launch(12'h000, 13'd4, 16'h07FE);
        step(8);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_data[i] !== ed[i]) begin
                failures++;
                $display("FAIL inc_data[%0d]: got %h, want %h", i, log_data[i], ed[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_wrap_host();
        test_zero_count();
        test_full_clamp();
        test_abort();
        test_start_beats_abort();
        test_back_to_back_host();
        test_inc_feature();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
